// File: rtl/gsram_seq_if.sv
// gsram_seq_if: bundles the sequencer's control, upstream handshake,
// gSRAM drive and readout stream signals.
//   slave  : the sequencer side (gsram_seq)
//   master : the environment side (controller, upstream, gSRAM, consumer)
// Signals:
//   start, mode, src_sel         pass request and its latched options
//   in_valid / in_ready          upstream fill handshake
//   ram_row, ram_col, ram_we,
//   ram_gate, ram_inmuxsel       gSRAM drive
//   ram_rdata                    registered gSRAM read data
//   out_valid / out_ready,
//   out_data, out_last           readout stream
//   busy, done                   pass status
interface gsram_seq_if #(
  parameter int DW = 16
);
  logic          start;
  logic          mode;
  logic          src_sel;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    ram_row;
  logic [3:0]    ram_col;
  logic          ram_we;
  logic          ram_gate;
  logic          ram_inmuxsel;
  logic [DW-1:0] ram_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  modport slave (
    input  start, mode, src_sel, in_valid, ram_rdata, out_ready,
    output in_ready, ram_row, ram_col, ram_we, ram_gate, ram_inmuxsel,
           out_valid, out_data, out_last, busy, done
  );

  modport master (
    output start, mode, src_sel, in_valid, ram_rdata, out_ready,
    input  in_ready, ram_row, ram_col, ram_we, ram_gate, ram_inmuxsel,
           out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/gsram_seq.sv
// gsram_seq: address and handshake sequencer for the ROWS x COLS x DW gSRAM
// tile. Fill mode writes one accepted upstream word per cell in row-major
// order; readout mode scans every cell and streams the registered read data
// out over a valid/ready handshake.
// Ports:
//   clk    rising-edge clock, shared with the gSRAM
//   rst_n  synchronous active-low reset
//   bus    gsram_seq_if.slave (control, handshakes, gSRAM drive)
// Build option:
//   GSRAM_SEQ_COLMAJOR_READ_EN  when defined, readout scans column-major
//                               (transposed readout); fill stays row-major.
//
// state | meaning
// IDLE  | waiting for start; mode/src_sel latched on start
// FILL  | one write per in_valid beat, row-major
// READ  | issuing reads whenever the output slot is free or being drained
// DRAIN | last word in flight, waiting for downstream acceptance
// DONE  | one-cycle done pulse
module gsram_seq #(
  parameter int ROWS = 10,
  parameter int COLS = 10,
  parameter int DW   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  gsram_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
  localparam logic [3:0] COL_LAST = 4'(COLS - 1);

  state_t        state, state_nx;
  logic [3:0]    row_q, col_q;
  logic          out_valid_q;
  logic          inmuxsel_q;
  logic [DW-1:0] rdata_w;

  logic last_cell, beat, issue, accept, advance, col_major;

  assign last_cell = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign beat      = (state == S_FILL) && bus.in_valid;
  // A read may be issued when the output slot is empty or is being drained
  // this cycle; otherwise the gate stays off so the gSRAM output holds.
  assign issue     = (state == S_READ) && (!out_valid_q || bus.out_ready);
  assign accept    = out_valid_q && bus.out_ready;
  assign advance   = beat || issue;

`ifdef GSRAM_SEQ_COLMAJOR_READ_EN
  assign col_major = (state == S_READ);
`else
  assign col_major = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.start) state_nx = bus.mode ? S_READ : S_FILL;
      S_FILL:  if (beat && last_cell) state_nx = S_DONE;
      S_READ:  if (issue && last_cell) state_nx = S_DRAIN;
      S_DRAIN: if (accept) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q       <= 4'd0;
      col_q       <= 4'd0;
      out_valid_q <= 1'b0;
      inmuxsel_q  <= 1'b0;
    end else begin
      if ((state == S_IDLE) && bus.start) begin
        row_q      <= 4'd0;
        col_q      <= 4'd0;
        inmuxsel_q <= bus.src_sel;
      end else if (advance) begin
        // Both scan orders end at the same corner cell, so the wrap to
        // (0,0) after it is shared.
        if (last_cell) begin
          row_q <= 4'd0;
          col_q <= 4'd0;
        end else if (col_major) begin
          if (row_q == ROW_LAST) begin
            row_q <= 4'd0;
            col_q <= col_q + 4'd1;
          end else begin
            row_q <= row_q + 4'd1;
          end
        end else begin
          if (col_q == COL_LAST) begin
            col_q <= 4'd0;
            row_q <= row_q + 4'd1;
          end else begin
            col_q <= col_q + 4'd1;
          end
        end
      end

      if (issue)       out_valid_q <= 1'b1;
      else if (accept) out_valid_q <= 1'b0;
    end
  end

  always_comb begin
    bus.in_ready = 1'b0;
    bus.ram_we   = 1'b0;
    bus.ram_gate = 1'b0;
    bus.out_last = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state)
      S_FILL: begin
        bus.in_ready = 1'b1;
        bus.ram_we   = beat;
        bus.ram_gate = beat;
        bus.busy     = 1'b1;
      end
      S_READ: begin
        bus.ram_gate = issue;
        bus.busy     = 1'b1;
      end
      S_DRAIN: begin
        bus.out_last = out_valid_q;
        bus.busy     = 1'b1;
      end
      S_DONE: begin
        bus.done = 1'b1;
        bus.busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign rdata_w          = bus.ram_rdata;
  assign bus.out_data     = rdata_w;
  assign bus.out_valid    = out_valid_q;
  assign bus.ram_row      = row_q;
  assign bus.ram_col      = col_q;
  assign bus.ram_inmuxsel = inmuxsel_q;

endmodule

// File: tb/tb_gsram_seq.sv
// tb_gsram_seq: self-checking bench for gsram_seq with a behavioural
// 10x10x16 gSRAM (write at the gated edge, registered read).
module tb_gsram_seq;
  localparam int ROWS  = 10;
  localparam int COLS  = 10;
  localparam int DW    = 16;
  localparam int NCELL = ROWS * COLS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gsram_seq_if #(.DW(DW)) bus ();

  gsram_seq #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // gSRAM model
  logic [DW-1:0] mem [NCELL];
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata_q = '0;
  int n_writes = 0;
  assign bus.ram_rdata = rdata_q;

  always @(posedge clk) begin
    if (bus.ram_gate && int'(bus.ram_row) < ROWS && int'(bus.ram_col) < COLS) begin
      if (bus.ram_we) begin
        mem[int'(bus.ram_row) * COLS + int'(bus.ram_col)] <= wdata;
        n_writes <= n_writes + 1;
      end else begin
        rdata_q <= mem[int'(bus.ram_row) * COLS + int'(bus.ram_col)];
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int beats = 0;
  int w_base = 0;

  typedef struct {
    bit iv;
    bit we;
    int row;
    int col;
  } fvec_t;
  fvec_t tab [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_word(input int k);
`ifdef GSRAM_SEQ_COLMAJOR_READ_EN
    return (k % ROWS) * COLS + k / ROWS;
`else
    return k;
`endif
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_done"},      bus.done, 0);
    chk({tag, "_in_ready"},  bus.in_ready, 0);
    chk({tag, "_we"},        bus.ram_we, 0);
    chk({tag, "_gate"},      bus.ram_gate, 0);
    chk({tag, "_row"},       bus.ram_row, 0);
    chk({tag, "_col"},       bus.ram_col, 0);
    chk({tag, "_inmuxsel"},  bus.ram_inmuxsel, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_last"},  bus.out_last, 0);
  endtask

  task automatic apply_reset(input int n, input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (n) @(negedge clk);
    #1;
    check_zero(tag);
    rst_n = 1'b1;
  endtask

  task automatic fill_start(input bit src);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 1'b0;
    bus.src_sel = src;
    bus.in_valid = 1'b0;
    #1;
    chk("idle_in_ready", bus.in_ready, 0);
    beats = 0;
    w_base = n_writes;
  endtask

  task automatic fill_beats(input int target, input bit gapped, input bit src,
                            input int base, input bit pulse_start);
    int guard = 0;
    while (beats < target && guard < 4 * NCELL) begin
      @(negedge clk);
      bus.start = pulse_start && (guard == 5);
      bus.mode = 1'b1;
      bus.in_valid = gapped ? !bus.in_valid : 1'b1;
      wdata = DW'(base + beats);
      #1;
      chk("fill_we",       bus.ram_we, bus.in_valid);
      chk("fill_gate",     bus.ram_gate, bus.in_valid);
      chk("fill_in_ready", bus.in_ready, 1);
      chk("fill_row",      bus.ram_row, beats / COLS);
      chk("fill_col",      bus.ram_col, beats % COLS);
      chk("fill_inmuxsel", bus.ram_inmuxsel, src);
      if (bus.in_valid) beats++;
      guard++;
    end
    if (beats < target) chk("fill_timeout", beats, target);
  endtask

  task automatic fill_finish();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    #1;
    chk("fill_done_pulse", bus.done, 1);
    chk("fill_done_in_ready", bus.in_ready, 0);
    chk("fill_done_busy", bus.busy, 1);
    chk("fill_write_count", n_writes - w_base, NCELL);
    @(negedge clk);
    #1;
    chk("fill_done_clear", bus.done, 0);
    chk("fill_idle_busy", bus.busy, 0);
  endtask

  task automatic do_read(input int stall_at, input int stall_len, input int abort_at);
    int n_rx = 0;
    int stall_rem = 0;
    bit stalled = 1'b0;
    bit fin = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 1'b1;
    bus.src_sel = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 600 && !fin; k++) begin
      @(negedge clk);
      bus.start = (k == 7);
      bus.mode = 1'b0;
      if (k == abort_at) begin
        apply_reset(2, "rst_read");
        fin = 1'b1;
      end else begin
        bus.out_ready = (stall_rem == 0);
        #1;
        if (bus.out_valid && n_rx == stall_at && !stalled) begin
          stalled = 1'b1;
          stall_rem = stall_len;
          bus.out_ready = 1'b0;
          #1;
        end
        if (k == 7) chk("start_ignored_in_ready", bus.in_ready, 0);
        if (bus.done) begin
          chk("read_word_count", n_rx, NCELL);
          chk("read_done_cycle", k, 102 + (stalled ? stall_len : 0));
          fin = 1'b1;
        end else if (!bus.out_ready) begin
          chk("stall_gate",  bus.ram_gate, 0);
          chk("stall_valid", bus.out_valid, 1);
          chk("stall_data",  bus.out_data, exp_word(n_rx));
          stall_rem--;
        end else if (bus.out_valid) begin
          chk("read_data", bus.out_data, exp_word(n_rx));
          chk("read_last", bus.out_last, n_rx == NCELL - 1);
          n_rx++;
        end else if (k >= 2) begin
          chk("read_gap", bus.out_valid, 1);
        end
      end
    end
    if (!fin) chk("read_timeout", 0, 1);
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    tab = '{
      '{1'b1, 1'b1, 0, 0}, '{1'b0, 1'b0, 0, 1}, '{1'b1, 1'b1, 0, 1},
      '{1'b1, 1'b1, 0, 2}, '{1'b0, 1'b0, 0, 3}, '{1'b0, 1'b0, 0, 3},
      '{1'b1, 1'b1, 0, 3}, '{1'b1, 1'b1, 0, 4}, '{1'b1, 1'b1, 0, 5},
      '{1'b1, 1'b1, 0, 6}, '{1'b1, 1'b1, 0, 7}, '{1'b1, 1'b1, 0, 8},
      '{1'b1, 1'b1, 0, 9}, '{1'b0, 1'b0, 1, 0}, '{1'b1, 1'b1, 1, 0}
    };
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.src_sel = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    apply_reset(2, "rst_init");

    // Partial fill with junk, start pulse mid-pass, then abort by reset.
    fill_start(1'b0);
    fill_beats(37, 1'b0, 1'b0, 32'hA000, 1'b1);
    apply_reset(1, "rst_fill");

    // Gapped fill: table-driven opening (restart at (0,0)), then toggling.
    fill_start(1'b1);
    foreach (tab[i]) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.in_valid = tab[i].iv;
      wdata = DW'(beats);
      #1;
      chk("tab_we",   bus.ram_we, tab[i].we);
      chk("tab_gate", bus.ram_gate, tab[i].we);
      chk("tab_row",  bus.ram_row, tab[i].row);
      chk("tab_col",  bus.ram_col, tab[i].col);
      if (tab[i].iv) beats++;
    end
    fill_beats(NCELL, 1'b1, 1'b1, 0, 1'b0);
    fill_finish();

    // Continuous fill of the same words.
    fill_start(1'b1);
    fill_beats(NCELL, 1'b0, 1'b1, 0, 1'b0);
    fill_finish();

    do_read(40, 5, -1);
    do_read(-1, 0, 20);
    do_read(-1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gsram_seq.md
# gsram_seq

Address and handshake sequencer for the 10×10×16-bit gSRAM tile. It sits directly upstream of the gSRAM and drives its `row`, `col`, `we`, `gate` and `inmuxsel` inputs. In fill mode it rasters one accepted upstream word into each cell. In readout mode it scans all cells and presents the registered `rdata` as a valid/ready stream to the downstream consumer.

## Interface
Parameters:
- `ROWS`, 10, number of array rows (max 16)
- `COLS`, 10, number of array columns (max 16)
- `DW`, 16, data width

Ports:
- `clk`  in  1  rising-edge clock; one clock, shared with the gSRAM
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  begin a pass; sampled only in IDLE
- `mode`  in  1  0 = fill, 1 = readout; sampled with `start`
- `src_sel`  in  1  fill source, 0 = m2result, 1 = lutdata; sampled with `start`
- `in_valid`  in  1  upstream word is present on the gSRAM data bus this cycle
- `in_ready`  out  1  sequencer accepts a word this cycle
- `ram_row`  out  4  gSRAM row address
- `ram_col`  out  4  gSRAM column address
- `ram_we`  out  1  gSRAM write enable
- `ram_gate`  out  1  gSRAM clock gate
- `ram_inmuxsel`  out  1  gSRAM write-source select
- `ram_rdata`  in  DW  gSRAM read data (registered inside the gSRAM)
- `out_valid`  out  1  readout word valid
- `out_ready`  in  1  downstream accepts the readout word
- `out_data`  out  DW  readout word; direct pass-through of `ram_rdata`
- `out_last`  out  1  qualifies the final readout word
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle pulse at the end of a pass

## Operation
- FSM states: IDLE, FILL, READ, DRAIN, DONE.
- IDLE with `start`=1 latches `mode` and `src_sel`, clears the counters, then goes to FILL (`mode`=0) or READ (`mode`=1). `start` is ignored in every other state.
- Scan order is row-major: `ram_col` increments fastest; at `COLS-1` it wraps to 0 and `ram_row` increments. The scan covers (0,0) through (`ROWS-1`,`COLS-1`), 100 cells at default parameters.
- FILL:
  - `in_ready`=1.
  - A beat is a cycle with `in_valid`=1. On a beat, `ram_we` and `ram_gate` are asserted combinationally; otherwise both are 0.
  - The counters advance only on beats.
  - `ram_inmuxsel` = latched `src_sel` throughout the pass.
  - On the beat at the last cell, go to DONE.
- READ:
  - `ram_we`=0. An issue is `ram_gate`=1; it happens when `!out_valid || out_ready`.
  - Each issue advances the counters.
  - `out_valid` is registered. It is set the cycle after an issue, and cleared on acceptance (`out_valid && out_ready`) when no new issue occurs in the same cycle.
  - While issue is blocked, `ram_gate`=0, so `ram_rdata` and `out_data` hold stable.
  - After issuing the last cell, go to DRAIN.
- DRAIN: no issues. `out_last`=`out_valid`. On acceptance, go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Reset (`rst_n`=0 at a clock edge, in any state, including mid-pass):
  - state goes to IDLE; `ram_row`, `ram_col`, `out_valid`, `ram_inmuxsel` and the latched mode all go to 0
  - all outputs are 0 the following cycle
  - gSRAM contents are not affected
  - a partial pass is abandoned; the next `start` restarts at (0,0)

## Timing
- Fill: write latency 0. A word presented with `in_valid` is written at that cycle's rising edge. At most 1 word per cycle. The `done` pulse comes 1 cycle after the last beat.
- Readout: an issue in cycle N produces `out_valid` in cycle N+1, carrying data for the cell addressed in cycle N. Sustained throughput is 1 word per cycle when `out_ready`=1.
- A full unstalled readout takes 1 + 100 + 1 cycles from `start` to `done`.
- `in_ready`=0 outside FILL. In-flight words are never dropped or duplicated under backpressure.

## Configuration
- `GSRAM_SEQ_COLMAJOR_READ_EN`:
  - Defined: READ scans column-major, with `ram_row` incrementing fastest and wrapping at `ROWS-1`. This gives a transposed readout. FILL stays row-major.
  - Undefined: both modes scan row-major.
  - In both builds the last cell is (`ROWS-1`,`COLS-1`).

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles mid-READ → every output 0 next cycle, `busy`=0; a subsequent readout returns the previously filled data.
- Fill: `start`, `mode`=0, `src_sel`=1, `in_valid`=1 with words 0x0000..0x0063 → 100 `ram_we`/`ram_gate` cycles, addresses (0,0)..(9,9), `ram_inmuxsel`=1, `done` 1 cycle after the 100th beat.
- Gapped fill: toggle `in_valid` every cycle → `ram_we`=0 on idle cycles, addresses advance only on beats, exactly 100 writes.
- Readout: `mode`=1, `out_ready`=1 after the fill above → 100 consecutive `out_valid` words 0x0000..0x0063 in order (column-major order 0x0000, 0x000A, 0x0014… when the macro is defined), `out_last` only with 0x0063.
- Backpressure: `out_ready`=0 for 5 cycles at word 40 → `out_data`=0x0028 held, `ram_gate`=0, resume with 0x0029, no drops or duplicates.
- Abort/restart: reset after 37 fill beats, then `start` → first write at (0,0); `start` pulses while `busy`=1 have no effect.
